// File: rtl/mult_seq_pkg.sv
// Shared types and phase constants for the multiplier phase sequencer.
// count_global phase map: calibration in 1..22, ADC sample window in 23..31.
package mult_seq_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StSeq,
      StAdc,
      StDone,
      StErr
   } state_e;

   typedef enum logic [1:0] {
      SelHold = 2'd0,
      SelStd  = 2'd1,
      SelZero = 2'd2,
      SelAdc  = 2'd3
   } mult_sel_e;

   localparam logic [4:0] PH_STD0     = 5'd1;
   localparam logic [4:0] PH_STD1     = 5'd7;
   localparam logic [4:0] PH_ZERO     = 5'd20;
   localparam logic [4:0] PH_LAST_SEQ = 5'd22;
   localparam logic [4:0] PH_ADC0     = 5'd23;
   localparam logic [4:0] PH_ADC_LAST = 5'd31;

   function automatic mult_sel_e phase_sel(input logic [4:0] ph);
      mult_sel_e sel;
      sel = SelHold;
      if (ph == PH_STD0 || ph == PH_STD1) begin
         sel = SelStd;
      end else if (ph == PH_ZERO) begin
         sel = SelZero;
      end else if (ph >= PH_ADC0) begin
         sel = SelAdc;
      end
      return sel;
   endfunction

endpackage

// File: rtl/mult_seq_wdog.sv
// ADC-window watchdog: counts consecutive idle ticks and flags expiry on the
// tick that would take the count past TIMEOUT-1.
module mult_seq_wdog #(
   parameter int unsigned TIMEOUT = 1024,
   parameter int unsigned CW      = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic tick,
   output logic expire
);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (tick) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign expire = tick && (cnt_q == CW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mult_phase_sequencer.sv
// Frame sequencer driving count_global / mult_sel for the mult datapath:
// calibration phases, accumulator clear, then a 9-sample ADC window per frame.
module mult_phase_sequencer
   import mult_seq_pkg::*;
#(
   parameter int unsigned NUM_FRAMES = 4,
   parameter int unsigned TIMEOUT    = 1024,
   parameter int unsigned CW         = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic       adc_valid,
   output logic       adc_ready,
   output logic [4:0] count_global,
   output logic [1:0] mult_sel,
   output logic       acc_en,
   output logic [7:0] frame_idx,
   output logic       busy,
   output logic       done,
   output logic       err
);

   state_e    state_q, state_d;
   logic [4:0] count_q, count_d;
   logic [7:0] frame_q, frame_d;
   mult_sel_e mult_sel_q, mult_sel_d;
   logic      adc_ready_q, adc_ready_d;
   logic      acc_en_q, acc_en_d;
   logic      busy_q, busy_d;
   logic      done_q, done_d;
   logic      err_q, err_d;

   logic accept;
   logic wdog_clr;
   logic wdog_tick;
   logic wdog_expire;

   // adc_ready_q is high exactly while state_q is StAdc
   assign accept    = adc_valid && adc_ready_q;
   assign wdog_tick = (state_q == StAdc) && !adc_valid;
   assign wdog_clr  = (state_q != StAdc) || accept || abort;

   mult_seq_wdog #(
      .TIMEOUT (TIMEOUT),
      .CW      (CW)
   ) u_wdog (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (wdog_clr),
      .tick   (wdog_tick),
      .expire (wdog_expire)
   );

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      frame_d = frame_q;

      unique case (state_q)
         StIdle, StErr: begin
            if (start) begin
               state_d = StSeq;
               count_d = PH_STD0;
               frame_d = 8'd0;
            end
         end
         StSeq: begin
            if (count_q == PH_LAST_SEQ) begin
               state_d = StAdc;
               count_d = PH_ADC0;
            end else begin
               count_d = count_q + 5'd1;
            end
         end
         StAdc: begin
            if (accept) begin
               if (count_q != PH_ADC_LAST) begin
                  count_d = count_q + 5'd1;
               end else if (frame_q == 8'(NUM_FRAMES - 1)) begin
                  state_d = StDone;
                  count_d = 5'd0;
               end else begin
                  state_d = StSeq;
                  count_d = PH_STD0;
                  frame_d = frame_q + 8'd1;
               end
            end else if (wdog_expire) begin
               state_d = StErr;
               count_d = 5'd0;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
            count_d = 5'd0;
         end
      endcase

      if (abort) begin
         state_d = StIdle;
         count_d = 5'd0;
         frame_d = 8'd0;
      end

      mult_sel_d  = phase_sel(count_d);
      adc_ready_d = (state_d == StAdc);
      acc_en_d    = accept && !abort;
      busy_d      = (state_d == StSeq) || (state_d == StAdc);
      done_d      = (state_d == StDone);
      err_d       = (state_d == StErr);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         count_q     <= 5'd0;
         frame_q     <= 8'd0;
         mult_sel_q  <= SelHold;
         adc_ready_q <= 1'b0;
         acc_en_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         frame_q     <= frame_d;
         mult_sel_q  <= mult_sel_d;
         adc_ready_q <= adc_ready_d;
         acc_en_q    <= acc_en_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign adc_ready    = adc_ready_q;
   assign count_global = count_q;
   assign mult_sel     = mult_sel_q;
   assign acc_en       = acc_en_q;
   assign frame_idx    = frame_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign err          = err_q;

endmodule

// File: tb/tb_mult_phase_sequencer.sv
// Directed bench for mult_phase_sequencer: instance a is single-frame, instance b
// runs four frames; both use an 8-cycle ADC timeout.
module tb_mult_phase_sequencer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic       a_start = 1'b0, a_abort = 1'b0, a_valid = 1'b0;
   logic       a_ready, a_acc, a_busy, a_done, a_err;
   logic [4:0] a_count;
   logic [1:0] a_sel;
   logic [7:0] a_frame;

   logic       b_start = 1'b0, b_abort = 1'b0, b_valid = 1'b0;
   logic       b_ready, b_acc, b_busy, b_done, b_err;
   logic [4:0] b_count;
   logic [1:0] b_sel;
   logic [7:0] b_frame;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mult_phase_sequencer #(
      .NUM_FRAMES (1),
      .TIMEOUT    (8),
      .CW         (4)
   ) u_dut_a (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (a_start),
      .abort        (a_abort),
      .adc_valid    (a_valid),
      .adc_ready    (a_ready),
      .count_global (a_count),
      .mult_sel     (a_sel),
      .acc_en       (a_acc),
      .frame_idx    (a_frame),
      .busy         (a_busy),
      .done         (a_done),
      .err          (a_err)
   );

   mult_phase_sequencer #(
      .NUM_FRAMES (4),
      .TIMEOUT    (8),
      .CW         (4)
   ) u_dut_b (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (b_start),
      .abort        (b_abort),
      .adc_valid    (b_valid),
      .adc_ready    (b_ready),
      .count_global (b_count),
      .mult_sel     (b_sel),
      .acc_en       (b_acc),
      .frame_idx    (b_frame),
      .busy         (b_busy),
      .done         (b_done),
      .err          (b_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      checks++;
      if ({a_count, a_sel, a_frame} !== 15'd0) begin
         errors++;
         $display("FAIL reset_a_values: got %0h required 0", {a_count, a_sel, a_frame});
      end
      checks++;
      if ({a_ready, a_acc, a_busy, a_done, a_err} !== 5'd0) begin
         errors++;
         $display("FAIL reset_a_flags: got %b required 00000",
                  {a_ready, a_acc, a_busy, a_done, a_err});
      end
      checks++;
      if ({b_count, b_sel, b_frame, b_ready, b_acc, b_busy, b_done, b_err} !== 20'd0) begin
         errors++;
         $display("FAIL reset_b: got %0h required 0",
                  {b_count, b_sel, b_frame, b_ready, b_acc, b_busy, b_done, b_err});
      end
      rst_n = 1'b1;
      step();
   endtask

   // Runs one frame on instance a with adc_valid high; start pulse must precede.
   task automatic run_full_frame_a(input string tag);
      logic [1:0] exp_sel;
      logic [3:0] exp_flags;
      for (int i = 1; i <= 31; i++) begin
         exp_sel   = (i == 1 || i == 7) ? 2'd1 : (i == 20) ? 2'd2 : (i >= 23) ? 2'd3 : 2'd0;
         exp_flags = {1'b1, (i >= 23), (i >= 24), 1'b0};
         checks++;
         if (a_count !== 5'(i)) begin
            errors++;
            $display("FAIL %s_count: got %0d required %0d", tag, a_count, i);
         end
         checks++;
         if (a_sel !== exp_sel) begin
            errors++;
            $display("FAIL %s_sel@%0d: got %0d required %0d", tag, i, a_sel, exp_sel);
         end
         checks++;
         if ({a_busy, a_ready, a_acc, a_done} !== exp_flags) begin
            errors++;
            $display("FAIL %s_flags@%0d: got %b required %b", tag, i,
                     {a_busy, a_ready, a_acc, a_done}, exp_flags);
         end
         step();
      end
      checks++;
      if ({a_done, a_acc, a_busy, a_count} !== {3'b110, 5'd0}) begin
         errors++;
         $display("FAIL %s_done: got %b required 11000000", tag, {a_done, a_acc, a_busy, a_count});
      end
      step();
      checks++;
      if ({a_done, a_busy, a_count} !== 7'd0) begin
         errors++;
         $display("FAIL %s_done_pulse: got %b required 0", tag, {a_done, a_busy, a_count});
      end
   endtask

   task automatic test_single_frame();
      a_valid = 1'b1;
      a_start = 1'b1;
      step();
      a_start = 1'b0;
      run_full_frame_a("single");
      a_valid = 1'b0;
   endtask

   task automatic test_multi_frame();
      int samples = 0, accs = 0, dones = 0, incs = 0, bad_range = 0;
      logic [7:0] prev_frame;
      b_start = 1'b1;
      step();
      b_start = 1'b0;
      prev_frame = b_frame;
      for (int c = 0; c < 400; c++) begin
         b_valid = (c % 3 == 2);
         if (b_valid && b_ready) samples++;
         if (b_acc) accs++;
         if (b_done) dones++;
         if (b_busy && b_frame == prev_frame + 8'd1) incs++;
         if (b_busy) prev_frame = b_frame;
         if (!b_ready && b_count >= 5'd24) bad_range++;
         step();
      end
      b_valid = 1'b0;
      checks++;
      if (samples != 36) begin
         errors++;
         $display("FAIL multi_samples: got %0d required 36", samples);
      end
      checks++;
      if (accs != 36) begin
         errors++;
         $display("FAIL multi_acc_en: got %0d required 36", accs);
      end
      checks++;
      if (dones != 1) begin
         errors++;
         $display("FAIL multi_done: got %0d required 1", dones);
      end
      checks++;
      if (incs != 3 || prev_frame != 8'd3) begin
         errors++;
         $display("FAIL multi_frame_idx: got incs=%0d last=%0d required 3/3", incs, prev_frame);
      end
      checks++;
      if (bad_range != 0 || b_busy !== 1'b0 || b_err !== 1'b0) begin
         errors++;
         $display("FAIL multi_end: got bad=%0d busy=%b err=%b required 0/0/0",
                  bad_range, b_busy, b_err);
      end
   endtask

   task automatic test_timeout();
      a_valid = 1'b0;
      a_start = 1'b1;
      step();
      a_start = 1'b0;
      repeat (22) step();
      checks++;
      if ({a_count, a_ready} !== {5'd23, 1'b1}) begin
         errors++;
         $display("FAIL to_adc_entry: got count=%0d ready=%b required 23/1", a_count, a_ready);
      end
      repeat (7) step();
      checks++;
      if ({a_err, a_count} !== {1'b0, 5'd23}) begin
         errors++;
         $display("FAIL to_early: got err=%b count=%0d required 0/23", a_err, a_count);
      end
      step();
      checks++;
      if ({a_err, a_count, a_busy, a_ready} !== {1'b1, 5'd0, 2'b00}) begin
         errors++;
         $display("FAIL to_err: got err=%b count=%0d busy=%b ready=%b required 1/0/0/0",
                  a_err, a_count, a_busy, a_ready);
      end
      repeat (3) step();
      checks++;
      if (a_err !== 1'b1) begin
         errors++;
         $display("FAIL to_sticky: got %b required 1", a_err);
      end
      a_start = 1'b1;
      step();
      a_start = 1'b0;
      checks++;
      if ({a_err, a_count, a_busy, a_frame} !== {1'b0, 5'd1, 1'b1, 8'd0}) begin
         errors++;
         $display("FAIL to_restart: got err=%b count=%0d busy=%b frame=%0d required 0/1/1/0",
                  a_err, a_count, a_busy, a_frame);
      end
   endtask

   // Continues from the restart left by test_timeout.
   task automatic test_boundary();
      repeat (22) step();
      repeat (7) step();
      checks++;
      if ({a_err, a_count} !== {1'b0, 5'd23}) begin
         errors++;
         $display("FAIL bound_pre: got err=%b count=%0d required 0/23", a_err, a_count);
      end
      a_valid = 1'b1;
      step();
      a_valid = 1'b0;
      checks++;
      if ({a_err, a_count, a_acc, a_ready} !== {1'b0, 5'd24, 2'b11}) begin
         errors++;
         $display("FAIL bound_accept: got err=%b count=%0d acc=%b ready=%b required 0/24/1/1",
                  a_err, a_count, a_acc, a_ready);
      end
      a_abort = 1'b1;
      step();
      a_abort = 1'b0;
      checks++;
      if ({a_busy, a_count} !== 6'd0) begin
         errors++;
         $display("FAIL bound_cleanup: got busy=%b count=%0d required 0/0", a_busy, a_count);
      end
   endtask

   task automatic test_abort();
      int dones = 0;
      a_valid = 1'b1;
      a_start = 1'b1;
      step();
      a_start = 1'b0;
      repeat (24) step();
      checks++;
      if (a_count !== 5'd25) begin
         errors++;
         $display("FAIL abort_pre: got %0d required 25", a_count);
      end
      a_abort = 1'b1;
      a_start = 1'b1;
      step();
      a_abort = 1'b0;
      a_start = 1'b0;
      checks++;
      if ({a_count, a_sel, a_frame, a_busy, a_done, a_err, a_ready} !== 19'd0) begin
         errors++;
         $display("FAIL abort_idle: got count=%0d sel=%0d frame=%0d flags=%b required 0",
                  a_count, a_sel, a_frame, {a_busy, a_done, a_err, a_ready});
      end
      for (int i = 0; i < 4; i++) begin
         if (a_done) dones++;
         step();
      end
      checks++;
      if (dones != 0 || a_count !== 5'd0) begin
         errors++;
         $display("FAIL abort_dropped: got dones=%0d count=%0d required 0/0", dones, a_count);
      end
      a_start = 1'b1;
      step();
      a_start = 1'b0;
      repeat (5) step();
      a_start = 1'b1;
      step();
      a_start = 1'b0;
      checks++;
      if (a_count !== 5'd7 || a_sel !== 2'd1) begin
         errors++;
         $display("FAIL seq_start_ignored: got count=%0d sel=%0d required 7/1", a_count, a_sel);
      end
      a_abort = 1'b1;
      step();
      a_abort = 1'b0;
   endtask

   task automatic test_reset_mid();
      a_valid = 1'b1;
      a_start = 1'b1;
      step();
      a_start = 1'b0;
      repeat (14) step();
      checks++;
      if (a_count !== 5'd15) begin
         errors++;
         $display("FAIL rstmid_pre: got %0d required 15", a_count);
      end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      checks++;
      if ({a_count, a_sel, a_frame, a_ready, a_acc, a_busy, a_done, a_err} !== 20'd0) begin
         errors++;
         $display("FAIL rstmid_values: got %0h required 0",
                  {a_count, a_sel, a_frame, a_ready, a_acc, a_busy, a_done, a_err});
      end
      step();
      a_start = 1'b1;
      step();
      a_start = 1'b0;
      run_full_frame_a("rstmid");
      a_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_multi_frame();
      test_timeout();
      test_boundary();
      test_abort();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
